// File: rtl/count_pkg.sv
// Shared constants and helpers for the cascadable modulo-N counter.
// Optional feature macro: COUNTN_DOWN_EN (adds bidirectional counting).
package count_pkg;

  localparam int unsigned MOD_DEF    = 10;
  localparam int unsigned WIDTH_DEF  = 4;
  localparam int unsigned DIGITS_DEF = 2;

  // Direction encoding on the UP input
  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  // Loaded digit values at or above the modulus saturate to the top digit value
  function automatic int unsigned clamp_digit(input int unsigned value,
                                              input int unsigned modulus);
    return (value >= modulus) ? modulus - 1 : value;
  endfunction

endpackage

// File: rtl/count_modn_digit.sv
// One modulo-MOD digit register with load, step enable and terminal carry.
// Optional feature macro: COUNTN_DOWN_EN (adds the up port and borrow logic).
module count_modn_digit
  import count_pkg::*;
#(
  parameter int unsigned MOD   = MOD_DEF,
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ci,
`ifdef COUNTN_DOWN_EN
  input  logic             up,
`endif
  input  logic             ld,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             co
);

  localparam logic [WIDTH-1:0] MAX = WIDTH'(MOD - 1);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;
  logic             term_c;

  // Next digit value: load (clamped) beats step, step wraps at the modulus
  always_comb begin
    q_d = q_q;
    if (ld) begin
      q_d = WIDTH'(clamp_digit(32'(d), MOD));
    end else if (ci) begin
`ifdef COUNTN_DOWN_EN
      if (up == DIR_UP) begin
        q_d = (q_q == MAX) ? '0 : q_q + WIDTH'(1);
      end else begin
        q_d = (q_q == '0) ? MAX : q_q - WIDTH'(1);
      end
`else
      q_d = (q_q == MAX) ? '0 : q_q + WIDTH'(1);
`endif
    end
  end

  // Digit sits at the value from which the next step wraps
  always_comb begin
    term_c = (q_q == MAX);
`ifdef COUNTN_DOWN_EN
    if (up == DIR_DOWN) begin
      term_c = (q_q == '0);
    end
`endif
  end

  // Digit state register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q  = q_q;
  assign co = ci & term_c;

endmodule

// File: rtl/count_modn_chain.sv
// Cascadable DIGITS-stage modulo-MOD counter with load, enable and carry out.
// Optional feature macro: COUNTN_DOWN_EN (adds UP port, bidirectional count).
module count_modn_chain
  import count_pkg::*;
#(
  parameter int unsigned MOD    = MOD_DEF,
  parameter int unsigned WIDTH  = WIDTH_DEF,
  parameter int unsigned DIGITS = DIGITS_DEF
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    EN,
`ifdef COUNTN_DOWN_EN
  input  logic                    UP,
`endif
  input  logic                    LD,
  input  logic [DIGITS*WIDTH-1:0] D,
  output logic [DIGITS*WIDTH-1:0] Q,
  output logic                    CY
);

  // Digit chain: each stage steps when EN and every lower stage is terminal
  for (genvar k = 0; k < DIGITS; k++) begin : g_digit
    logic ci;
    logic co;

    if (k == 0) begin : g_first
      assign ci = EN;
    end else begin : g_next
      assign ci = g_digit[k-1].co;
    end

    count_modn_digit #(
      .MOD   (MOD),
      .WIDTH (WIDTH)
    ) u_digit (
      .clk (CLK),
      .rst (RST),
      .ci  (ci),
`ifdef COUNTN_DOWN_EN
      .up  (UP),
`endif
      .ld  (LD),
      .d   (D[k*WIDTH +: WIDTH]),
      .q   (Q[k*WIDTH +: WIDTH]),
      .co  (co)
    );
  end

  // Cascade carry: whole chain terminal and enabled, suppressed by reset/load
  assign CY = g_digit[DIGITS-1].co & ~RST & ~LD;

endmodule

// File: tb/tb_count_modn_chain.sv
// Bench for count_modn_chain: decimal pair, MOD-6 pair, and a cascaded 4-digit pair.
module tb_count_modn_chain;

  localparam int unsigned NA = 100;
  localparam int unsigned NB = 36;
  localparam int unsigned NC = 10000;

  logic        clk;
  logic        rst, en, up, ld;
  logic [7:0]  da, qa;
  logic [5:0]  db, qb;
  logic [15:0] dc, qc;
  logic        cya, cyb, cy_lo, cy_c;

  int          n_checks = 0;
  int          n_fail   = 0;
  int unsigned va, vb, vc;
  bit          valid = 1'b0;

  count_modn_chain #(.MOD(10), .WIDTH(4), .DIGITS(2)) u_dut_a (
    .CLK (clk), .RST (rst), .EN (en),
`ifdef COUNTN_DOWN_EN
    .UP  (up),
`endif
    .LD  (ld), .D (da), .Q (qa), .CY (cya)
  );

  count_modn_chain #(.MOD(6), .WIDTH(3), .DIGITS(2)) u_dut_b (
    .CLK (clk), .RST (rst), .EN (en),
`ifdef COUNTN_DOWN_EN
    .UP  (up),
`endif
    .LD  (ld), .D (db), .Q (qb), .CY (cyb)
  );

  count_modn_chain #(.MOD(10), .WIDTH(4), .DIGITS(2)) u_dut_c_lo (
    .CLK (clk), .RST (rst), .EN (en),
`ifdef COUNTN_DOWN_EN
    .UP  (up),
`endif
    .LD  (ld), .D (dc[7:0]), .Q (qc[7:0]), .CY (cy_lo)
  );

  count_modn_chain #(.MOD(10), .WIDTH(4), .DIGITS(2)) u_dut_c_hi (
    .CLK (clk), .RST (rst), .EN (cy_lo),
`ifdef COUNTN_DOWN_EN
    .UP  (up),
`endif
    .LD  (ld), .D (dc[15:8]), .Q (qc[15:8]), .CY (cy_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int unsigned ipow(input int unsigned m, input int unsigned k);
    int unsigned r = 1;
    for (int unsigned i = 0; i < k; i++) r = r * m;
    return r;
  endfunction

  // Integer count value -> packed digit word
  function automatic logic [31:0] pack(input int unsigned v, input int unsigned m,
                                       input int unsigned w, input int unsigned n);
    logic [31:0] r = '0;
    for (int unsigned k = 0; k < n; k++)
      r = r | (32'((v / ipow(m, k)) % m) << (k * w));
    return r;
  endfunction

  // Packed load word -> integer count value, each digit clamped to m-1
  function automatic int unsigned load_val(input logic [31:0] d, input int unsigned m,
                                           input int unsigned w, input int unsigned n);
    int unsigned v = 0;
    int unsigned dig;
    for (int unsigned k = 0; k < n; k++) begin
      dig = (d >> (k * w)) & ((32'd1 << w) - 1);
      if (dig >= m) dig = m - 1;
      v = v + dig * ipow(m, k);
    end
    return v;
  endfunction

  function automatic int unsigned step(input int unsigned v, input int unsigned n);
    return up ? (v + 1) % n : (v + n - 1) % n;
  endfunction

  function automatic logic exp_cy(input int unsigned v, input int unsigned n);
    return en && !rst && !ld && (up ? (v == n - 1) : (v == 0));
  endfunction

  // Reference model: each counter is one integer modulo MOD**DIGITS
  always @(posedge clk) begin
    if (rst) begin
      va = 0; vb = 0; vc = 0;
      valid = 1'b1;
    end else if (ld) begin
      va = load_val(32'(da), 10, 4, 2);
      vb = load_val(32'(db), 6, 3, 2);
      vc = load_val(32'(dc), 10, 4, 4);
    end else if (en) begin
      va = step(va, NA);
      vb = step(vb, NB);
      vc = step(vc, NC);
    end
  end

  // Every-cycle comparison against the model, mid-cycle
  always @(negedge clk) begin
    if (valid) begin
      check("A_Q",  32'(qa),   pack(va, 10, 4, 2));
      check("A_CY", 32'(cya),  32'(exp_cy(va, NA)));
      check("B_Q",  32'(qb),   pack(vb, 6, 3, 2));
      check("B_CY", 32'(cyb),  32'(exp_cy(vb, NB)));
      check("C_Q",  32'(qc),   pack(vc, 10, 4, 4));
      check("C_CY", 32'(cy_c), 32'(exp_cy(vc, NC)));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; up = 1'b1; ld = 1'b0;
    da = '0; db = '0; dc = '0;

    // Reset with enable asserted
    repeat (2) tick();
    check("rst_A_Q", 32'(qa), 32'h00);
    check("rst_A_CY", 32'(cya), 32'h0);
    check("rst_C_Q", 32'(qc), 32'h0000);
    rst = 1'b0;

    // Count up from zero; pin MOD-6 carries and decimal terminal
    for (int i = 1; i <= 99; i++) begin
      tick();
      if (i == 6)  check("B_carry6_Q", 32'(qb), 32'h08);
      if (i == 35) begin
        check("B_term_Q", 32'(qb), 32'h2D);
        check("B_term_CY", 32'(cyb), 32'h1);
      end
      if (i == 36) begin
        check("B_wrap_Q", 32'(qb), 32'h00);
        check("B_wrap_CY", 32'(cyb), 32'h0);
      end
    end
    check("A_99_Q", 32'(qa), 32'h99);
    check("A_99_CY", 32'(cya), 32'h1);
    check("C_99_CY", 32'(cy_c), 32'h0);
    tick();
    check("A_wrap_Q", 32'(qa), 32'h00);
    check("A_wrap_CY", 32'(cya), 32'h0);
    check("C_100_Q", 32'(qc), 32'h0100);

    // Enable gap
    repeat (19) tick();
    check("A_19_Q", 32'(qa), 32'h19);
    en = 1'b0;
    tick();
    check("gap_hold_Q", 32'(qa), 32'h19);
    check("gap_CY", 32'(cya), 32'h0);
    en = 1'b1;
    tick();
    check("gap_resume_Q", 32'(qa), 32'h20);

    // Load with clamp, then load under reset
    ld = 1'b1; da = 8'h3C;
    tick();
    check("ld_clamp_Q", 32'(qa), 32'h39);
    check("ld_CY", 32'(cya), 32'h0);
    rst = 1'b1;
    tick();
    check("ld_rst_Q", 32'(qa), 32'h00);
    rst = 1'b0; ld = 1'b0;

`ifdef COUNTN_DOWN_EN
    // Down count through the borrow wrap
    ld = 1'b1; da = 8'h01;
    tick();
    check("dn_ld_Q", 32'(qa), 32'h01);
    ld = 1'b0; up = 1'b0; en = 1'b1;
    tick();
    check("dn_zero_Q", 32'(qa), 32'h00);
    check("dn_zero_CY", 32'(cya), 32'h1);
    tick();
    check("dn_wrap_Q", 32'(qa), 32'h99);
    check("dn_wrap_CY", 32'(cya), 32'h0);
    up = 1'b1;
`endif

    // Randomised controls, checked every cycle by the model compare
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 99) == 0);
      ld  = ($urandom_range(0, 19) == 0);
      en  = ($urandom_range(0, 3) != 0);
`ifdef COUNTN_DOWN_EN
      if ($urandom_range(0, 31) == 0) up = ~up;
`endif
      da = ($urandom_range(0, 2) == 0) ? 8'h98 : 8'($urandom);
      db = 6'($urandom);
      dc = ($urandom_range(0, 2) == 0) ? 16'h9998 : ($urandom_range(0, 1) == 0) ? 16'h0001
                                       : 16'($urandom);
      tick();
    end

    rst = 1'b0; ld = 1'b0; en = 1'b0;
    tick();
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
